// File: rtl/sha256_stream_hasher_if.sv
// Handshake bundle for sha256_stream_hasher: padded-block input channel and
// digest output channel. The optional sha224 select exists only when
// SHA256_SHA224_EN is defined.
interface sha256_stream_hasher_if #(
  parameter int BLOCK_W  = 512,
  parameter int DIGEST_W = 256
);
  logic                src_data_val;
  logic [BLOCK_W-1:0]  src_data;
  logic                src_data_last;
  logic                src_rdy;
`ifdef SHA256_SHA224_EN
  logic                sha224;
`endif
  logic                digest_val;
  logic [DIGEST_W-1:0] digest;
  logic                dst_digest_rdy;

  // block source / digest consumer side
  modport master (
`ifdef SHA256_SHA224_EN
    output sha224,
`endif
    output src_data_val, src_data, src_data_last, dst_digest_rdy,
    input  src_rdy, digest_val, digest
  );

  // hasher side
  modport slave (
`ifdef SHA256_SHA224_EN
    input  sha224,
`endif
    input  src_data_val, src_data, src_data_last, dst_digest_rdy,
    output src_rdy, digest_val, digest
  );
endinterface

// File: rtl/sha256_stream_hasher.sv
// Streaming SHA-256 engine: takes pre-padded 512-bit blocks, runs one
// compression round per cycle (66 cycles per block) and presents the
// 256-bit digest after the block flagged last.
// Optional SHA-224 mode is compiled in with SHA256_SHA224_EN.
module sha256_stream_hasher (
  input  logic                 clk,
  input  logic                 rst,
  sha256_stream_hasher_if.slave bus
);

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
`ifdef SHA256_SHA224_EN
  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, OUT} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t            state, state_nxt;
  logic [5:0]        t;
  // w[15] is W[t]; w[15-k] is W[t+k]
  logic [15:0][31:0] w;
  logic [31:0]       a, b, c, d, e, f, g, h;
  // hv[7] is H0, hv[0] is H7 - same layout as the digest port
  logic [7:0][31:0]  hv;
  logic              first;      // next accepted block starts a message
  logic              blk_first;  // block in flight started its message
  logic              last;
  logic              rdy, dval, accept;
  logic [255:0]      iv_in, iv_msg;
  logic [7:0][31:0]  base, work;
  logic [31:0]       t1, t2, w_new;

`ifdef SHA256_SHA224_EN
  logic mode224;
  assign iv_in      = bus.sha224 ? IV224 : IV256;
  assign iv_msg     = mode224 ? IV224 : IV256;
  assign bus.digest = {hv[7:1], hv[0] & {32{~mode224}}};

  // mode is fixed for the whole message by its first block
  always_ff @(posedge clk or posedge rst)
    if (rst)                 mode224 <= 1'b0;
    else if (accept && first) mode224 <= bus.sha224;
`else
  assign iv_in      = IV256;
  assign iv_msg     = IV256;
  assign bus.digest = hv;
`endif

  assign accept         = (state == IDLE) && bus.src_data_val;
  assign bus.src_rdy    = rdy;
  assign bus.digest_val = dval;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // next-state and handshake outputs; src_rdy is masked while rst is held
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    dval      = 1'b0;
    case (state)
      IDLE: begin
        rdy = ~rst;
        if (bus.src_data_val) state_nxt = ROUND;
      end
      ROUND:  if (t == 6'd63) state_nxt = UPDATE;
      UPDATE: state_nxt = last ? OUT : IDLE;
      OUT: begin
        dval = 1'b1;
        if (bus.dst_digest_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // round function, schedule extension and chaining-value base
  always_comb begin
    t1    = h + bsig1(e) + ((e & f) ^ (~e & g)) + K[t] + w[15];
    t2    = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    w_new = ssig1(w[1]) + w[6] + ssig0(w[14]) + w[15];
    // H is never preloaded with the IV, so the digest port holds the
    // previous result until this block's UPDATE
    base  = blk_first ? iv_msg : hv;
    work  = {a, b, c, d, e, f, g, h};
  end

  // datapath: block capture, rounds, chaining-value update
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      t         <= '0;
      w         <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      hv        <= '0;
      first     <= 1'b1;
      blk_first <= 1'b0;
      last      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          w         <= bus.src_data;
          last      <= bus.src_data_last;
          blk_first <= first;
          first     <= 1'b0;
          t         <= '0;
          {a, b, c, d, e, f, g, h} <= first ? iv_in : hv;
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          w <= {w[14:0], w_new};
          t <= t + 6'd1;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) hv[i] <= base[i] + work[i];
          if (last) first <= 1'b1;
        end
        default: ;
      endcase
    end

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Directed bench for sha256_stream_hasher: known-answer digests, block and
// digest timing, backpressure, message restart and mid-message reset.
// SHA-224 vector runs when SHA256_SHA224_EN is defined.
module tb_sha256_stream_hasher;

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_2B =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_SHA224_EN
  localparam logic [255:0] D_224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  int   n;
  logic ok;

  always #5 clk = ~clk;

  sha256_stream_hasher_if bus();
  sha256_stream_hasher dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one block handshake; the accepting edge is the edge inside tick()
  task automatic send(input string tag, input logic [511:0] blk, input logic lst);
    chk({tag, "_rdy"}, bus.src_rdy, 1'b1);
    bus.src_data      = blk;
    bus.src_data_last = lst;
    bus.src_data_val  = 1'b1;
    tick();
    bus.src_data_val  = 1'b0;
    chk({tag, "_busy"}, bus.src_rdy, 1'b0);
  endtask

  task automatic wait_dval(output int cnt);
    cnt = 0;
    while (bus.digest_val !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_rdy(output int cnt);
    cnt = 0;
    while (bus.src_rdy !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.src_data_val   = 1'b0;
    bus.src_data       = '0;
    bus.src_data_last  = 1'b0;
    bus.dst_digest_rdy = 1'b1;
`ifdef SHA256_SHA224_EN
    bus.sha224         = 1'b0;
`endif
    #1;
    chk("rst_src_rdy", bus.src_rdy, 1'b0);
    chk("rst_dval", bus.digest_val, 1'b0);
    chk("rst_digest", bus.digest, '0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", bus.src_rdy, 1'b1);

    // single block "abc"
    send("abc", ABC, 1'b1);
    wait_dval(n);
    chk("abc_latency", n, 65);
    chk("abc_digest", bus.digest, D_ABC);
    chk("abc_out_rdy", bus.src_rdy, 1'b0);
    tick();
    chk("abc_dval_fall", bus.digest_val, 1'b0);
    chk("abc_idle_rdy", bus.src_rdy, 1'b1);
    chk("abc_digest_kept", bus.digest, D_ABC);

    // two-block message
    send("b1", B1, 1'b0);
    wait_rdy(n);
    chk("b1_gap", n, 65);
    chk("b1_no_dval", bus.digest_val, 1'b0);
    send("b2", B2, 1'b1);
    wait_dval(n);
    chk("b2_latency", n, 65);
    chk("two_block_digest", bus.digest, D_2B);
    tick();

    // digest backpressure for 20 cycles
    bus.dst_digest_rdy = 1'b0;
    send("bp", ABC, 1'b1);
    wait_dval(n);
    chk("bp_latency", n, 65);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.digest_val !== 1'b1 || bus.digest !== D_ABC || bus.src_rdy !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("bp_stable", ok, 1'b1);
    chk("bp_still_val", bus.digest_val, 1'b1);
    bus.dst_digest_rdy = 1'b1;
    tick();
    chk("bp_release_dval", bus.digest_val, 1'b0);
    chk("bp_release_rdy", bus.src_rdy, 1'b1);
    chk("bp_digest_kept", bus.digest, D_ABC);

    // second "abc" right after the first: IV must be reloaded
    send("b2b", ABC, 1'b1);
    wait_dval(n);
    chk("b2b_digest", bus.digest, D_ABC);
    tick();

    // reset in the middle of a multi-block message
    send("abort", B1, 1'b0);
    repeat (30) tick();
    rst = 1'b1;
    #1;
    chk("abort_rst_rdy", bus.src_rdy, 1'b0);
    chk("abort_rst_dval", bus.digest_val, 1'b0);
    chk("abort_rst_digest", bus.digest, '0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_post_rdy", bus.src_rdy, 1'b1);
    send("after_abort", ABC, 1'b1);
    wait_dval(n);
    chk("after_abort_latency", n, 65);
    chk("after_abort_digest", bus.digest, D_ABC);
    tick();

`ifdef SHA256_SHA224_EN
    bus.sha224 = 1'b1;
    send("s224", ABC, 1'b1);
    bus.sha224 = 1'b0;
    wait_dval(n);
    chk("s224_digest", bus.digest, D_224);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
